// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths and reset defaults for the multi-channel clock divider.
// Revision 1.0
`default_nettype none

package clk_div_pkg;

  localparam int          WR_CH_W         = 3;
  localparam int unsigned DEF_DIV_DEFAULT = 32'd49_999_999;

endpackage

`default_nettype wire

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control/status bundle of the multi-channel clock divider.
// Revision 1.0
`default_nettype none

interface clk_div_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 26
);
  import clk_div_pkg::*;

  logic [NCH-1:0]     en;
  logic               sync;
  logic               wr_en;
  logic [WR_CH_W-1:0] wr_ch;
  logic [CNT_W-1:0]   wr_div;
  logic [NCH-1:0]     tick;
  logic [NCH-1:0]     clk_out;
  logic [NCH-1:0]     busy;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  tick, clk_out, busy
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output tick, clk_out, busy
  );

endinterface

`default_nettype wire

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel - counter, shadow divisor, tick pulse and toggle output.
// Revision 1.0
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W   = 26,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en_i,
  input  wire logic             sync_i,
  input  wire logic             wr_i,
  input  wire logic [CNT_W-1:0] wr_div_i,
  output logic                  tick_o,
  output logic                  clk_out_o,
  output logic                  busy_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic [CNT_W-1:0] s_q, s_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             w_apply;

  always_comb begin
    c_d       = c_q;
    d_d       = d_q;
    s_d       = s_q;
    busy_d    = busy_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    w_apply   = 1'b0;

    if (sync_i || !en_i) begin
      c_d       = '0;
      clk_out_d = 1'b0;
      w_apply   = 1'b1;
    end else if (c_q >= d_q) begin
      c_d       = '0;
      tick_d    = 1'b1;
      clk_out_d = ~clk_out_q;
      w_apply   = 1'b1;
    end else begin
      c_d = c_q + CNT_W'(1);
    end

    // A fresh write supersedes any pending value and waits for the next boundary.
    if (wr_i) begin
      s_d    = wr_div_i;
      busy_d = 1'b1;
    end else if (w_apply && busy_q) begin
      d_d    = s_q;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q       <= '0;
      d_q       <= RST_DIV;
      s_q       <= RST_DIV;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      c_q       <= c_d;
      d_q       <= d_d;
      s_q       <= s_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign busy_o    = busy_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable dividers; top level decodes writes and fans out.
// Revision 1.0
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          CNT_W   = 26,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  clk_div_multi_if.slave   bus
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic w_wr_sel;

    // Indices at or above NCH match no channel and are dropped.
    assign w_wr_sel = bus.wr_en && (bus.wr_ch == WR_CH_W'(i));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (bus.en[i]),
      .sync_i    (bus.sync),
      .wr_i      (w_wr_sel),
      .wr_div_i  (bus.wr_div),
      .tick_o    (bus.tick[i]),
      .clk_out_o (bus.clk_out[i]),
      .busy_o    (bus.busy[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed self-checking bench for clk_div_multi (reset divisor shortened to 19).
// Revision 1.0
`default_nettype none

module tb_clk_div_multi;

  localparam int NCH   = 4;
  localparam int CNT_W = 26;
  localparam int DEFD  = 19;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  clk_div_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  clk_div_multi #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEFD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until tick[ch] is seen high; -1 if not seen within budget.
  task automatic wait_tick(input int ch, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (bus.tick[ch] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_write(input int ch, input int val);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'(ch);
    bus.wr_div = CNT_W'(val);
    step(1);
    bus.wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n      = 1'b0;
    bus.en     = '0;
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;
    step(3);
    n_tests++;
    if (bus.tick !== 4'b0000) begin n_fail++; $display("FAIL reset_tick: got %b, expected 0000", bus.tick); end
    n_tests++;
    if (bus.clk_out !== 4'b0000) begin n_fail++; $display("FAIL reset_clk_out: got %b, expected 0000", bus.clk_out); end
    n_tests++;
    if (bus.busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0000", bus.busy); end
    rst_n  = 1'b1;
    bus.en = 4'b0001;
    wait_tick(0, 60, n);
    n_tests++;
    if (n !== DEFD + 1) begin n_fail++; $display("FAIL reset_first_tick: got %0d, expected %0d", n, DEFD + 1); end
    n_tests++;
    if (bus.clk_out[0] !== 1'b1) begin n_fail++; $display("FAIL reset_clk_out_rise: got %b, expected 1", bus.clk_out[0]); end
    wait_tick(0, 60, n);
    n_tests++;
    if (n !== DEFD + 1) begin n_fail++; $display("FAIL reset_second_tick: got %0d, expected %0d", n, DEFD + 1); end
    n_tests++;
    if (bus.clk_out[0] !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out_fall: got %b, expected 0", bus.clk_out[0]); end
  endtask

  task automatic test_reprogram();
    int n;
    do_write(1, 9);
    step(1);
    bus.en = 4'b0011;
    wait_tick(1, 40, n);
    n_tests++;
    if (n !== 10) begin n_fail++; $display("FAIL reprog_d9_first: got %0d, expected 10", n); end
    step(4);
    do_write(1, 3);
    n_tests++;
    if (bus.busy[1] !== 1'b1) begin n_fail++; $display("FAIL reprog_busy_set: got %b, expected 1", bus.busy[1]); end
    wait_tick(1, 40, n);
    n_tests++;
    if (n !== 5) begin n_fail++; $display("FAIL reprog_period_completes: got %0d, expected 5", n); end
    n_tests++;
    if (bus.busy[1] !== 1'b0) begin n_fail++; $display("FAIL reprog_busy_clear: got %b, expected 0", bus.busy[1]); end
    for (int k = 0; k < 2; k++) begin
      wait_tick(1, 40, n);
      n_tests++;
      if (n !== 4) begin n_fail++; $display("FAIL reprog_new_period: got %0d, expected 4", n); end
    end
  endtask

  task automatic test_boundary();
    int   n;
    logic prev;
    do_write(2, 0);
    step(1);
    bus.en = 4'b0111;
    wait_tick(2, 10, n);
    n_tests++;
    if (n !== 1) begin n_fail++; $display("FAIL bnd_d0_first: got %0d, expected 1", n); end
    for (int k = 0; k < 4; k++) begin
      prev = bus.clk_out[2];
      step(1);
      n_tests++;
      if (bus.tick[2] !== 1'b1) begin n_fail++; $display("FAIL bnd_d0_tick: got %b, expected 1", bus.tick[2]); end
      n_tests++;
      if (bus.clk_out[2] !== ~prev) begin n_fail++; $display("FAIL bnd_d0_toggle: got %b, expected %b", bus.clk_out[2], ~prev); end
    end
    do_write(2, 3);
    wait_tick(2, 10, n);
    wait_tick(2, 20, n);
    n_tests++;
    if (n !== 4) begin n_fail++; $display("FAIL bnd_d3_period: got %0d, expected 4", n); end
    step(3);
    do_write(2, 0);
    n_tests++;
    if (bus.tick[2] !== 1'b1) begin n_fail++; $display("FAIL bnd_tc_align: got %b, expected 1", bus.tick[2]); end
    n_tests++;
    if (bus.busy[2] !== 1'b1) begin n_fail++; $display("FAIL bnd_tc_busy: got %b, expected 1", bus.busy[2]); end
    wait_tick(2, 20, n);
    n_tests++;
    if (n !== 4) begin n_fail++; $display("FAIL bnd_tc_write_deferred: got %0d, expected 4", n); end
    n_tests++;
    if (bus.busy[2] !== 1'b0) begin n_fail++; $display("FAIL bnd_tc_busy_clear: got %b, expected 0", bus.busy[2]); end
    wait_tick(2, 20, n);
    n_tests++;
    if (n !== 1) begin n_fail++; $display("FAIL bnd_tc_write_applied: got %0d, expected 1", n); end
  endtask

  task automatic test_sync();
    int f0;
    int f1;
    bus.en = 4'b0100;
    do_write(0, 4);
    do_write(1, 6);
    step(1);
    bus.en = 4'b0111;
    step(14);
    bus.sync = 1'b1;
    step(1);
    bus.sync = 1'b0;
    n_tests++;
    if (bus.tick !== 4'b0000) begin n_fail++; $display("FAIL sync_tick_suppressed: got %b, expected 0000", bus.tick); end
    n_tests++;
    if (bus.clk_out !== 4'b0000) begin n_fail++; $display("FAIL sync_clk_out_clear: got %b, expected 0000", bus.clk_out); end
    f0 = -1;
    f1 = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (bus.tick[0] === 1'b1 && f0 < 0) f0 = k;
      if (bus.tick[1] === 1'b1 && f1 < 0) f1 = k;
    end
    n_tests++;
    if (f0 !== 5) begin n_fail++; $display("FAIL sync_first_tick_ch0: got %0d, expected 5", f0); end
    n_tests++;
    if (f1 !== 7) begin n_fail++; $display("FAIL sync_first_tick_ch1: got %0d, expected 7", f1); end
  endtask

  task automatic test_enable_reset();
    int n;
    bus.en = 4'b0011;
    do_write(2, 9);
    step(1);
    bus.en = 4'b0111;
    wait_tick(2, 40, n);
    n_tests++;
    if (n !== 10) begin n_fail++; $display("FAIL en_first_tick: got %0d, expected 10", n); end
    step(9);
    bus.en = 4'b0011;
    step(1);
    n_tests++;
    if (bus.tick[2] !== 1'b0) begin n_fail++; $display("FAIL en_drop_tick: got %b, expected 0", bus.tick[2]); end
    n_tests++;
    if (bus.clk_out[2] !== 1'b0) begin n_fail++; $display("FAIL en_drop_clk_out: got %b, expected 0", bus.clk_out[2]); end
    bus.en = 4'b0111;
    wait_tick(2, 40, n);
    n_tests++;
    if (n !== 10) begin n_fail++; $display("FAIL en_restart_tick: got %0d, expected 10", n); end
    do_write(0, 2);
    n_tests++;
    if (bus.busy[0] !== 1'b1 || bus.clk_out[2] !== 1'b1) begin
      n_fail++; $display("FAIL rst_precondition: got busy0=%b clk_out2=%b, expected 1 1", bus.busy[0], bus.clk_out[2]);
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.tick !== 4'b0000 || bus.clk_out !== 4'b0000 || bus.busy !== 4'b0000) begin
      n_fail++; $display("FAIL rst_async_clear: got tick=%b clk_out=%b busy=%b, expected all 0000", bus.tick, bus.clk_out, bus.busy);
    end
    step(2);
    rst_n  = 1'b1;
    bus.en = 4'b0001;
    wait_tick(0, 60, n);
    n_tests++;
    if (n !== DEFD + 1) begin n_fail++; $display("FAIL rst_discard_pending: got %0d, expected %0d", n, DEFD + 1); end
  endtask

  task automatic test_illegal();
    int n;
    do_write(5, 2);
    n_tests++;
    if (bus.busy !== 4'b0000) begin n_fail++; $display("FAIL illegal_wr5_busy: got %b, expected 0000", bus.busy); end
    do_write(4, 2);
    n_tests++;
    if (bus.busy !== 4'b0000) begin n_fail++; $display("FAIL illegal_wr4_busy: got %b, expected 0000", bus.busy); end
    wait_tick(0, 60, n);
    n_tests++;
    if (n !== DEFD - 1) begin n_fail++; $display("FAIL illegal_period_rest: got %0d, expected %0d", n, DEFD - 1); end
    wait_tick(0, 60, n);
    n_tests++;
    if (n !== DEFD + 1) begin n_fail++; $display("FAIL illegal_period_kept: got %0d, expected %0d", n, DEFD + 1); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_reprogram();
    test_boundary();
    test_sync();
    test_enable_reset();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
